// File: rtl/rtc_prog_pkg.sv
// ----------------------------------------------------------------------------
// rtc_prog_pkg
// Shared definitions for the RTC write sequencer: ctrl_W code constants,
// FSM state encoding, the fixed INIT code table and the PROG mask scan helper.
// No ports (package).
// ----------------------------------------------------------------------------
package rtc_prog_pkg;

    // Control codes presented to the RTC write decoder
    localparam logic [4:0] CODE_IDLE    = 5'd0;
    localparam logic [4:0] CODE_FIN     = 5'd21;
    localparam logic [4:0] CODE_BUSIDLE = 5'd22;
    localparam logic [4:0] CODE_INIT0   = 5'd23;
    localparam logic [4:0] CODE_INIT1   = 5'd24;
    localparam logic [4:0] CODE_INIT2   = 5'd25;
    localparam logic [4:0] CODE_INIT3   = 5'd26;
    localparam logic [4:0] CODE_INIT4   = 5'd27;
    localparam logic [4:0] CODE_INIT5   = 5'd28;
    localparam logic [4:0] CODE_HANDOFF = 5'd29;

    localparam int unsigned NUM_PAIRS = 10;

    typedef enum logic [2:0] {
        StIdle,
        StInitRun,
        StProgRun,
        StFinish,
        StHandoff
    } state_e;

    // INIT sequence indexed by position. Entry 7 is the FINISH code so the
    // step after the last INIT code reads straight out of the table.
    localparam logic [7:0][4:0] INIT_SEQ = {
        CODE_FIN,
        CODE_INIT5, CODE_INIT4, CODE_INIT3,
        CODE_INIT2, CODE_INIT1, CODE_INIT0,
        CODE_BUSIDLE
    };

    // Lowest set mask bit at or above 'from'. Result: {found, index}.
    function automatic logic [4:0] next_pair(input logic [9:0] mask,
                                             input logic [3:0] from);
        logic       found;
        logic [3:0] idx;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (!found && (4'(k) >= from) && mask[k]) begin
                found = 1'b1;
                idx   = 4'(k);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// ----------------------------------------------------------------------------
// rtc_phase_timer
// Phase hold timer. A load presets the down-counter to PHASE_CYCLES-1; the
// phase ends on the cycle the counter sits at zero, so every code loaded
// together with the timer is held exactly PHASE_CYCLES clocks.
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-high reset (counter -> 0)
//   i_load        restart the phase (new code being presented)
//   o_phase_end   high during the last clock of the current phase
// ----------------------------------------------------------------------------
module rtc_phase_timer #(
    parameter int unsigned PHASE_CYCLES = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    output logic o_phase_end
);

    localparam int unsigned CNT_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PHASE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_phase_end = (r_cnt == '0);

endmodule

// File: rtl/rtc_prog_sequencer.sv
// ----------------------------------------------------------------------------
// rtc_prog_sequencer
// Drives the 5-bit ctrl_W code of the RTC write decoder through the INIT or
// PROG bus sequence, holding each code PHASE_CYCLES clocks, skipping masked
// register pairs and handing the bus back to the read engine with a done pulse.
// Optional feature macro: PROG_ABORT_EN (abort during INIT/PROG run jumps to
// the 21/29 tail at the next phase boundary). Undefined: i_abort is ignored.
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_init_start  INIT request (sampled in IDLE only, wins over PROG)
//   i_prog_start  PROG request (sampled in IDLE only)
//   i_reg_mask    PROG pair-enable mask, latched on acceptance
//   i_abort       abort request (PROG_ABORT_EN only)
//   o_ctrl_w      registered control code to the write decoder
//   o_busy        sequence in progress
//   o_done        one-cycle pulse on return to IDLE
//   o_step_idx    debug position within sequence (wraps mod 16), 0 in IDLE
// ----------------------------------------------------------------------------
module rtc_prog_sequencer
    import rtc_prog_pkg::*;
#(
    parameter int unsigned PHASE_CYCLES = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_init_start,
    input  logic       i_prog_start,
    input  logic [9:0] i_reg_mask,
    input  logic       i_abort,
    output logic [4:0] o_ctrl_w,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_step_idx
);

    state_e     r_state, w_state_nxt;
    logic [4:0] r_ctrl, w_ctrl_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic [3:0] r_step, w_step_nxt;
    logic [9:0] r_mask, w_mask_nxt;
    logic       w_load;
    logic       w_phase_end;
    logic       w_abort_go;
    logic       w_running;
    logic [4:0] w_pair;
    logic [3:0] w_pair_from;

    assign w_running = (r_state == StInitRun) || (r_state == StProgRun);

    rtc_phase_timer #(
        .PHASE_CYCLES (PHASE_CYCLES)
    ) u_timer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .o_phase_end (w_phase_end)
    );

`ifdef PROG_ABORT_EN
    logic r_abort_pend;

    // Remember an abort seen during a run; it is consumed at the boundary
    // that moves the FSM into FINISH.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_abort_pend <= 1'b0;
        end else begin
            r_abort_pend <= w_running && !(w_phase_end && r_abort_pend)
                            && (r_abort_pend || i_abort);
        end
    end

    assign w_abort_go = r_abort_pend;
`else
    logic w_unused_abort;
    assign w_unused_abort = i_abort;
    assign w_abort_go     = 1'b0;
`endif

    // Search start for the next enabled pair: 0 after the bus-idle code,
    // k+1 after data code 2k+2.
    assign w_pair_from = (r_ctrl == CODE_BUSIDLE) ? 4'd0 : r_ctrl[4:1];
    assign w_pair      = next_pair(r_mask, w_pair_from);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_ctrl  <= CODE_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_step  <= 4'd0;
            r_mask  <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_step  <= w_step_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step_nxt  = r_step;
        w_mask_nxt  = r_mask;
        w_load      = 1'b0;

        unique case (r_state)
            StIdle: begin
                // A request coinciding with the done pulse is dropped.
                if (!r_done && (i_init_start || i_prog_start)) begin
                    w_ctrl_nxt  = CODE_BUSIDLE;
                    w_busy_nxt  = 1'b1;
                    w_step_nxt  = 4'd0;
                    w_load      = 1'b1;
                    if (i_init_start) begin
                        w_state_nxt = StInitRun;
                    end else begin
                        w_state_nxt = StProgRun;
                        w_mask_nxt  = i_reg_mask;
                    end
                end
            end

            StInitRun: begin
                if (w_phase_end) begin
                    w_load     = 1'b1;
                    w_step_nxt = r_step + 4'd1;
                    if (w_abort_go || r_step >= 4'd6) begin
                        w_ctrl_nxt  = CODE_FIN;
                        w_state_nxt = StFinish;
                    end else begin
                        w_ctrl_nxt = INIT_SEQ[r_step[2:0] + 3'd1];
                    end
                end
            end

            StProgRun: begin
                if (w_phase_end) begin
                    w_load     = 1'b1;
                    w_step_nxt = r_step + 4'd1;
                    if (w_abort_go) begin
                        w_ctrl_nxt  = CODE_FIN;
                        w_state_nxt = StFinish;
                    end else if (r_ctrl[0] && r_ctrl != CODE_FIN) begin
                        // address phase 2k+1 -> data phase 2k+2
                        w_ctrl_nxt = r_ctrl + 5'd1;
                    end else if (w_pair[4]) begin
                        w_ctrl_nxt = {w_pair[3:0], 1'b0} + 5'd1;
                    end else begin
                        w_ctrl_nxt  = CODE_FIN;
                        w_state_nxt = StFinish;
                    end
                end
            end

            StFinish: begin
                if (w_phase_end) begin
                    w_load      = 1'b1;
                    w_step_nxt  = r_step + 4'd1;
                    w_ctrl_nxt  = CODE_HANDOFF;
                    w_state_nxt = StHandoff;
                end
            end

            StHandoff: begin
                if (w_phase_end) begin
                    w_ctrl_nxt  = CODE_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_step_nxt  = 4'd0;
                    w_state_nxt = StIdle;
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_ctrl_nxt  = CODE_IDLE;
                w_busy_nxt  = 1'b0;
                w_step_nxt  = 4'd0;
            end
        endcase
    end

    assign o_ctrl_w   = r_ctrl;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_step_idx = r_step;

endmodule

// File: tb/tb_rtc_prog_sequencer.sv
module tb_rtc_prog_sequencer;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_s;
    logic       prog_s;
    logic       abort;
    logic [9:0] mask;
    logic [4:0] ctrl;
    logic       busy;
    logic       done;
    logic [3:0] step;

    always #5 clk = ~clk;

    rtc_prog_sequencer #(
        .PHASE_CYCLES (P)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_init_start (init_s),
        .i_prog_start (prog_s),
        .i_reg_mask   (mask),
        .i_abort      (abort),
        .o_ctrl_w     (ctrl),
        .o_busy       (busy),
        .o_done       (done),
        .o_step_idx   (step)
    );

    typedef struct {
        logic       init;
        logic       prog;
        logic [9:0] mask;
        logic [9:0] mask_mid;
        logic       pulse_busy;
        int         exp_busy;
    } vec_t;

    typedef struct {
        logic [4:0] code;
        int         pos;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_code(input logic [4:0] c, inout int pos);
        exp_t e;
        e.code = c;
        e.pos  = pos;
        repeat (P) sb.push_back(e);
        pos++;
    endtask

    // Expected code list straight from the sequence definitions
    task automatic push_seq(input logic is_init, input logic [9:0] m);
        int pos;
        pos = 0;
        push_code(5'd22, pos);
        if (is_init) begin
            for (int c = 23; c <= 28; c++) push_code(5'(c), pos);
        end else begin
            for (int k = 0; k < 10; k++) begin
                if (m[k]) begin
                    push_code(5'(2 * k + 1), pos);
                    push_code(5'(2 * k + 2), pos);
                end
            end
        end
        push_code(5'd21, pos);
        push_code(5'd29, pos);
    endtask

    // Pop and compare one expectation per clock until the scoreboard is empty
    task automatic drain(input string tag, input logic pulse, output int nbusy);
        exp_t e;
        int   n;
        nbusy = 0;
        n     = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " ctrl"}, int'(ctrl), int'(e.code));
            check({tag, " busy"}, int'(busy), 1);
            if (e.pos < 16) check({tag, " step"}, int'(step), e.pos);
            if (busy) nbusy++;
            n++;
            init_s = pulse && (n == 10);
            prog_s = pulse && (n == 10);
            @(negedge clk);
        end
        init_s = 1'b0;
        prog_s = 1'b0;
    endtask

    // Exit cycle checks, plus a start during done that must be ignored
    task automatic finish_check(input string tag);
        check({tag, " done"}, int'(done), 1);
        check({tag, " ctrl idle"}, int'(ctrl), 0);
        check({tag, " busy low"}, int'(busy), 0);
        check({tag, " step idle"}, int'(step), 0);
        prog_s = 1'b1;
        mask   = 10'h3FF;
        @(negedge clk);
        prog_s = 1'b0;
        check({tag, " start with done ignored"}, int'(busy), 0);
        check({tag, " done one cycle"}, int'(done), 0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int nb;
        init_s = v.init;
        prog_s = v.prog;
        mask   = v.mask;
        push_seq(v.init, v.mask);
        @(negedge clk);
        init_s = 1'b0;
        prog_s = 1'b0;
        mask   = v.mask_mid;
        drain(tag, v.pulse_busy, nb);
        check({tag, " busy cycles"}, nb, v.exp_busy);
        finish_check(tag);
    endtask

    task automatic wait_code(input string tag, input logic [4:0] c);
        int i;
        i = 0;
        while (ctrl != c && i < 200) begin
            @(negedge clk);
            i++;
        end
        check({tag, " reached code"}, int'(ctrl), int'(c));
    endtask

    vec_t vecs[6];

    initial begin
        int   pos;
        int   nb;
        exp_t e;

        vecs[0] = '{1'b1, 1'b0, 10'h000, 10'h000, 1'b0, 36};
        vecs[1] = '{1'b0, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 92};
        vecs[2] = '{1'b0, 1'b1, 10'h021, 10'h3FF, 1'b0, 28};
        vecs[3] = '{1'b1, 1'b1, 10'h3FF, 10'h3FF, 1'b1, 36};
        vecs[4] = '{1'b0, 1'b1, 10'h000, 10'h3FF, 1'b1, 12};
        vecs[5] = '{1'b0, 1'b1, 10'h200, 10'h000, 1'b0, 20};

        rst    = 1'b1;
        init_s = 1'b0;
        prog_s = 1'b0;
        abort  = 1'b0;
        mask   = 10'h0;
        #1;
        check("reset ctrl", int'(ctrl), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset step", int'(step), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", int'(busy), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of code 7
        prog_s = 1'b1;
        mask   = 10'h3FF;
        @(negedge clk);
        prog_s = 1'b0;
        wait_code("rst", 5'd7);
        #2 rst = 1'b1;
        #1;
        check("async rst ctrl", int'(ctrl), 0);
        check("async rst busy", int'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post rst idle", int'(busy), 0);
        run_vec("after rst", '{1'b0, 1'b1, 10'h021, 10'h021, 1'b0, 28});

        // Abort while code 5 is on the bus
        prog_s = 1'b1;
        mask   = 10'h3FF;
        @(negedge clk);
        prog_s = 1'b0;
        wait_code("abort", 5'd5);
        abort  = 1'b1;
        e.code = 5'd5;
        e.pos  = 5;
        repeat (P - 1) sb.push_back(e);
        pos = 6;
`ifdef PROG_ABORT_EN
        push_code(5'd21, pos);
        push_code(5'd29, pos);
`else
        for (int c = 6; c <= 20; c++) push_code(5'(c), pos);
        push_code(5'd21, pos);
        push_code(5'd29, pos);
`endif
        @(negedge clk);
        abort = 1'b0;
        drain("abort", 1'b0, nb);
        finish_check("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
